// File: rtl/par2ser_stream_pkg.sv
// par2ser_stream_pkg: shared types and helpers for the stream converters
package par2ser_stream_pkg;

    typedef enum logic {IDLE, SHIFT} state_t;

    typedef struct packed {
        logic valid;
        logic ready;
        logic last;
    } stream_hs_t;

    function automatic int clog2p1(input int x);
        return $clog2(x + 1);
    endfunction

endpackage

// File: rtl/par2ser_stream_if.sv
// par2ser_stream_if: parallel-in / serial-out handshake bundle
interface par2ser_stream_if
    import par2ser_stream_pkg::*;
#(
    parameter int DW = 8,
    parameter int L  = 4,
    parameter int CW = clog2p1(L)
);
    logic                 in_valid;
    logic                 in_ready;
    logic [L-1:0][DW-1:0] in_data;
    logic [CW-1:0]        in_len;
    logic                 out_valid;
    logic                 out_ready;
    logic [DW-1:0]        out_data;
    logic                 out_last;

    modport master (
        output in_valid, in_data, in_len, out_ready,
        input  in_ready, out_valid, out_data, out_last
    );

    modport slave (
        input  in_valid, in_data, in_len, out_ready,
        output in_ready, out_valid, out_data, out_last
    );
endinterface

// File: rtl/par2ser_stream.sv
// par2ser_stream: emits a loaded word vector one word per cycle, oldest (index n-1) first
module par2ser_stream
    import par2ser_stream_pkg::*;
#(
    parameter int DW = 8,
    parameter int L  = 4
) (
    input  logic            clk,
    input  logic            rst,
    par2ser_stream_if.slave io_bus
);
    localparam int CW = clog2p1(L);

    state_t               r_state, w_state_nxt;
    logic [CW-1:0]        r_cnt, w_cnt_nxt, w_len, w_idx;
    logic [L-1:0][DW-1:0] r_buf, w_buf_nxt;
    logic                 w_load;
    stream_hs_t           w_hs;

    assign w_len  = (io_bus.in_len == '0 || io_bus.in_len > CW'(L)) ? CW'(L) : io_bus.in_len;
    assign w_idx  = r_cnt - CW'(1);
    assign w_load = io_bus.in_valid && w_hs.ready;

    // handshake flags; ready reopens on the last word's accept so vectors chain without bubbles
    always_comb begin
        w_hs       = '0;
        w_hs.valid = !rst && r_state == SHIFT;
        w_hs.ready = !rst && (r_state == IDLE || (r_cnt == CW'(1) && io_bus.out_ready));
        w_hs.last  = w_hs.valid && r_cnt == CW'(1);
    end

    assign io_bus.in_ready  = w_hs.ready;
    assign io_bus.out_valid = w_hs.valid;
    assign io_bus.out_last  = w_hs.last;
    assign io_bus.out_data  = (r_state == SHIFT) ? r_buf[w_idx] : '0;

    // next state: a load wins over the final-word drain
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_buf_nxt   = r_buf;
        if (w_load) begin
            w_buf_nxt   = io_bus.in_data;
            w_cnt_nxt   = w_len;
            w_state_nxt = SHIFT;
        end else if (r_state == SHIFT && io_bus.out_ready) begin
            w_cnt_nxt   = w_idx;
            w_state_nxt = (r_cnt == CW'(1)) ? IDLE : SHIFT;
        end
    end

    // state, counter and word buffer registers
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_buf   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_buf   <= w_buf_nxt;
        end
    end
endmodule

// File: doc/par2ser_stream.md
Name: par2ser_stream

Overview:
- Parallel-in, serial-out stream converter. It is the inverse of the team's tapped serial-to-parallel delay line.
- Accepts one packed vector of up to L words over a valid/ready handshake. Emits the words one per cycle on a valid/ready serial output, oldest word first.
- Used wherever a tap-vector result (window, partial-sum row) must be returned to a word stream for a buffer write or a narrow bus.
- Ordering convention: index L-1 holds the oldest word and index 0 the newest. Feeding the serial output into a tapped delay line of depth n rebuilds the original vector.

Parameters:
- DW, 8, word width in bits.
- L, 4, maximum words per vector; L >= 1.
- CW, $clog2(L+1), localparam; width of the count and length fields.

Ports:
- clk  in  1  clock; all logic on posedge.
- rst  in  1  reset, synchronous, active-high.
- in_valid  in  1  parallel vector available.
- in_ready  out  1  block can accept a vector this cycle.
- in_data  in  L*DW  packed [L-1:0][DW-1:0]; word i at bits [i*DW +: DW].
- in_len  in  CW  number of words to emit, n. Valid range 1..L. Value 0 is treated as L. Values > L are illegal: they are clamped to L and flagged by a bench assertion.
- out_valid  out  1  serial word valid.
- out_ready  in  1  downstream accepts the word.
- out_data  out  DW  current serial word.
- out_last  out  1  high with the final word of the vector.

Behaviour:
- State: IDLE and SHIFT. Internal state is buf[L-1:0][DW-1:0] plus a down-counter cnt[CW-1:0].
- Reset (rst=1 at a posedge):
  - state <= IDLE, cnt <= 0, buf <= 0.
  - Outputs after reset: out_valid=0, out_last=0, out_data=0, in_ready=1.
  - While rst is high, in_ready=0 and out_valid=0.
  - Reset mid-vector abandons the remaining words immediately; no partial output follows.
- Load: when in_valid && in_ready at a posedge:
  - buf <= in_data.
  - cnt <= n (n = in_len, with 0 mapped to L).
  - state <= SHIFT.
- Outputs in SHIFT:
  - out_valid = 1.
  - out_data = buf[cnt-1].
  - out_last = (cnt == 1).
  - All three are decoded from registers only; there is no input-to-output combinational path on the data side.
  - In IDLE: out_valid=0, out_last=0, out_data=0.
- Emit: in SHIFT, when out_ready is high at a posedge, cnt <= cnt-1. When cnt was 1, the state moves to IDLE, unless a new load occurs in the same cycle.
- Emission order for length n: in_data[n-1], in_data[n-2], ..., in_data[0]. Words at indices >= n are never emitted.
- Latency: a vector accepted at edge t puts its first word on out_data in the cycle after t.
- Stall: while out_valid=1 and out_ready=0, out_data, out_last and cnt hold. Data never changes while valid is high without a handshake.
- in_ready = !rst && (state==IDLE || (cnt==1 && out_ready)).
  - This is the only combinational path: out_ready to in_ready.
  - Simultaneous last-word handshake and new load takes the load: state stays SHIFT, cnt <= new n.
  - Result: back-to-back vectors stream with zero bubbles. Throughput is 1 word/cycle.
- in_len=1 gives a single-word vector: out_last=1 on its only word, and in_ready follows out_ready in that cycle.
- in_valid while in_ready=0 is held by the upstream; data is not sampled.

Decomposition:
- Shared common package:
  - Function clog2p1(x) returning $clog2(x+1), used for CW.
  - Typedef of the stream handshake bundle (valid, ready, last), shared with future ser2par blocks.
- No sub-module. The counter/index mux is small enough to stay inline.
- The bench reuses the existing tapped delay line as a golden round-trip model.

Test Plan (L=4, DW=8):
- Reset then load in_data={8'h44,8'h33,8'h22,8'h11}, in_len=4, out_ready=1 -> out_data 0x44,0x33,0x22,0x11 on 4 consecutive cycles. out_last=1 only on 0x11. in_ready=0 for cycles 1-3 and 1 with the last word.
- Two vectors back-to-back (A with len 4, then B with len 2), in_valid held, out_ready=1 -> 6 consecutive valid words, no gap. B emits B[1] then B[0]. out_last pulses on A[0] and on B[0].
- Vector with in_len=2, then out_ready toggled 1,0,0,1 -> word 1 holds stable through 2 stall cycles. Exactly 2 words are emitted; out_last on in_data[0].
- in_len=0 -> 4 words emitted, identical to the in_len=4 case. in_len=1 -> a single word with out_last=1.
- rst asserted after the 2nd of 4 words -> next cycle out_valid=0, in_ready=1 after rst drops. The next vector starts from its own index n-1.
- Random lengths 1..4, random out_ready, 1000 vectors. Serial stream fed into a delay line of depth n -> taps equal the original in_data[n-1:0]. No word is lost or duplicated.
